// File: rtl/aes_sbox_shared_area.sv
// Area-optimised AES forward/inverse S-box sharing one GF((2^4)^2) inverter.
// The basis-change matrices are derived at elaboration from the field polynomials.
module aes_sbox_shared_area (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       encrypt,
    output logic [7:0] byte_out,
    output logic [7:0] byte_out_q
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NIB_W  = 4;

    // 8x8 GF(2) matrix stored column-major: column c occupies bits [8c +: 8]
    typedef logic [BYTE_W*BYTE_W-1:0] mat_t;

    // GF(2^4) multiply modulo x^4+x+1
    function automatic logic [NIB_W-1:0] gf4_mul(input logic [NIB_W-1:0] a,
                                                 input logic [NIB_W-1:0] b);
        logic [NIB_W-1:0] p;
        logic [NIB_W-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[2'(i)]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // GF(2^4) inverse as x^14; maps 0 to 0
    function automatic logic [NIB_W-1:0] gf4_inv(input logic [NIB_W-1:0] x);
        logic [NIB_W-1:0] x2;
        logic [NIB_W-1:0] x4;
        logic [NIB_W-1:0] x8;
        x2 = gf4_mul(x, x);
        x4 = gf4_mul(x2, x2);
        x8 = gf4_mul(x4, x4);
        return gf4_mul(gf4_mul(x8, x4), x2);
    endfunction

    // GF(2^8) multiply modulo 0x11B, used only while elaborating the bases
    function automatic logic [BYTE_W-1:0] gf8_mul(input logic [BYTE_W-1:0] a,
                                                  input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] p;
        logic [BYTE_W-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [BYTE_W-1:0] mat_apply(input mat_t m, input logic [BYTE_W-1:0] x);
        logic [BYTE_W-1:0] r;
        r = '0;
        for (int c = 0; c < 8; c++) begin
            if (x[3'(c)]) r = r ^ m[6'(c*8) +: 8];
        end
        return r;
    endfunction

    function automatic mat_t mat_mul(input mat_t x, input mat_t y);
        mat_t p;
        p = '0;
        for (int c = 0; c < 8; c++) begin
            p[6'(c*8) +: 8] = mat_apply(x, y[6'(c*8) +: 8]);
        end
        return p;
    endfunction

    // Gauss-Jordan by column operations: M*C reduces to I, so C is M^-1
    function automatic mat_t mat_inv(input mat_t m);
        mat_t              a;
        mat_t              b;
        logic [BYTE_W-1:0] tmp;
        int                piv;
        logic              found;
        a = m;
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[6'(c*8) +: 8] = 8'h01 << c;
        end
        for (int r = 0; r < 8; r++) begin
            piv   = r;
            found = 1'b0;
            for (int c = r; c < 8; c++) begin
                if (!found && a[6'(c*8 + r)]) begin
                    piv   = c;
                    found = 1'b1;
                end
            end
            tmp                 = a[6'(r*8) +: 8];
            a[6'(r*8) +: 8]     = a[6'(piv*8) +: 8];
            a[6'(piv*8) +: 8]   = tmp;
            tmp                 = b[6'(r*8) +: 8];
            b[6'(r*8) +: 8]     = b[6'(piv*8) +: 8];
            b[6'(piv*8) +: 8]   = tmp;
            for (int c = 0; c < 8; c++) begin
                if (c != r && a[6'(c*8 + r)]) begin
                    a[6'(c*8) +: 8] = a[6'(c*8) +: 8] ^ a[6'(r*8) +: 8];
                    b[6'(c*8) +: 8] = b[6'(c*8) +: 8] ^ b[6'(r*8) +: 8];
                end
            end
        end
        return b;
    endfunction

    // AES affine matrix: input bit c feeds output bits c..c+4 (mod 8)
    function automatic mat_t aff_mat();
        mat_t m;
        m = '0;
        for (int c = 0; c < 8; c++) begin
            m[6'(c*8) +: 8] = (8'h1F << c) | (8'h1F >> (8 - c));
        end
        return m;
    endfunction

    // Smallest lambda making y^2+y+lambda irreducible over GF(2^4)
    function automatic logic [NIB_W-1:0] find_lambda();
        logic [NIB_W-1:0] lam;
        logic             found;
        logic             root;
        lam   = '0;
        found = 1'b0;
        for (int l = 1; l < 16; l++) begin
            root = 1'b0;
            for (int t = 0; t < 16; t++) begin
                if ((gf4_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(l)) root = 1'b1;
            end
            if (!found && !root) begin
                lam   = 4'(l);
                found = 1'b1;
            end
        end
        return lam;
    endfunction

    // Root W of x^4+x+1 inside GF(2^8)
    function automatic logic [BYTE_W-1:0] find_w();
        logic [BYTE_W-1:0] w;
        logic [BYTE_W-1:0] v8;
        logic              found;
        w     = '0;
        found = 1'b0;
        for (int v = 2; v < 256; v++) begin
            v8 = 8'(v);
            if (!found && (gf8_mul(gf8_mul(gf8_mul(v8, v8), v8), v8) ^ v8) == 8'h01) begin
                w     = v8;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Root Y of y^2+y+lambda inside GF(2^8), lambda already lifted
    function automatic logic [BYTE_W-1:0] find_y(input logic [BYTE_W-1:0] lam8);
        logic [BYTE_W-1:0] y;
        logic [BYTE_W-1:0] v8;
        logic              found;
        y     = '0;
        found = 1'b0;
        for (int v = 2; v < 256; v++) begin
            v8 = 8'(v);
            if (!found && (gf8_mul(v8, v8) ^ v8) == lam8) begin
                y     = v8;
                found = 1'b1;
            end
        end
        return y;
    endfunction

    function automatic logic [BYTE_W-1:0] lift4(input logic [BYTE_W-1:0] w,
                                                input logic [NIB_W-1:0]  n);
        logic [BYTE_W-1:0] p;
        logic [BYTE_W-1:0] wp;
        p  = '0;
        wp = 8'h01;
        for (int j = 0; j < 4; j++) begin
            if (n[2'(j)]) p = p ^ wp;
            wp = gf8_mul(wp, w);
        end
        return p;
    endfunction

    // Composite {a1,a0} -> GF(2^8): basis W^j for a0 and Y*W^j for a1
    function automatic mat_t iso_mat(input logic [BYTE_W-1:0] w, input logic [BYTE_W-1:0] y);
        mat_t              m;
        logic [BYTE_W-1:0] wp;
        m  = '0;
        wp = 8'h01;
        for (int j = 0; j < 4; j++) begin
            m[6'(j*8) +: 8]       = wp;
            m[6'((4 + j)*8) +: 8] = gf8_mul(y, wp);
            wp = gf8_mul(wp, w);
        end
        return m;
    endfunction

    localparam logic [NIB_W-1:0]  LAMBDA   = find_lambda();
    localparam logic [BYTE_W-1:0] W_ROOT   = find_w();
    localparam logic [BYTE_W-1:0] Y_ROOT   = find_y(lift4(W_ROOT, LAMBDA));
    localparam mat_t              ISO      = iso_mat(W_ROOT, Y_ROOT);
    localparam mat_t              ISO_INV  = mat_inv(ISO);
    localparam mat_t              AFF      = aff_mat();
    localparam mat_t              AFF_INV  = mat_inv(AFF);
    localparam mat_t              IN_DEC   = mat_mul(ISO_INV, AFF_INV);
    localparam logic [BYTE_W-1:0] IN_DEC_C = mat_apply(ISO_INV, 8'h05);
    localparam mat_t              OUT_ENC  = mat_mul(AFF, ISO);

    logic [BYTE_W-1:0] in_t;
    logic [BYTE_W-1:0] inv_t;
    logic [NIB_W-1:0]  a1;
    logic [NIB_W-1:0]  a0;
    logic [NIB_W-1:0]  delta;
    logic [NIB_W-1:0]  delta_inv;

    // Shared datapath: input transform mux, single composite inverter, output transform mux
    always_comb begin
        in_t      = encrypt ? mat_apply(ISO_INV, byte_in)
                            : (mat_apply(IN_DEC, byte_in) ^ IN_DEC_C);
        a1        = in_t[7:4];
        a0        = in_t[3:0];
        delta     = gf4_mul(gf4_mul(a1, a1), LAMBDA) ^ gf4_mul(a1, a0) ^ gf4_mul(a0, a0);
        delta_inv = gf4_inv(delta);
        inv_t     = {gf4_mul(a1, delta_inv), gf4_mul(a0 ^ a1, delta_inv)};
        byte_out  = encrypt ? (mat_apply(OUT_ENC, inv_t) ^ 8'h63) : mat_apply(ISO, inv_t);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) byte_out_q <= '0;
        else        byte_out_q <= byte_out;
    end

endmodule

// File: tb/tb_aes_sbox_shared_area.sv
// Self-checking bench for aes_sbox_shared_area against a field-arithmetic reference model.
module tb_aes_sbox_shared_area;

    logic       clk;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       encrypt;
    logic [7:0] byte_out;
    logic [7:0] byte_out_q;

    int total;
    int bad;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    aes_sbox_shared_area dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .encrypt    (encrypt),
        .byte_out   (byte_out),
        .byte_out_q (byte_out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] acc;
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
        acc = prod[8:0];
        return acc[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // Build forward table from inversion + affine; inverse table by inverting the mapping
    task automatic build_model();
        logic [7:0] r;
        logic [7:0] bi;
        for (int x = 0; x < 256; x++) begin
            r = 8'h00;
            for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) r = 8'(y);
            bi = r;
            fwd_tab[x] = bi ^ rotl(bi, 1) ^ rotl(bi, 2) ^ rotl(bi, 3) ^ rotl(bi, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    endtask

    task automatic apply(input logic e, input logic [7:0] b);
        encrypt = e;
        byte_in = b;
        #1;
    endtask

    initial begin
        logic [7:0] y;
        logic [7:0] exp_q;
        logic [7:0] spot_in  [11];
        logic [7:0] spot_out [11];
        logic       spot_enc [11];
        total = 0;
        bad   = 0;
        rst_n   = 1'b0;
        encrypt = 1'b1;
        byte_in = 8'h00;
        build_model();
        #1;
        check("reset_q", byte_out_q, 8'h00);

        spot_in  = '{8'h00, 8'h01, 8'h10, 8'h53, 8'hFF, 8'h00, 8'h01, 8'h63, 8'h7C, 8'hED, 8'h16};
        spot_out = '{8'h63, 8'h7C, 8'hCA, 8'hED, 8'h16, 8'h52, 8'h09, 8'h00, 8'h01, 8'h53, 8'hFF};
        spot_enc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            apply(spot_enc[i], spot_in[i]);
            check(spot_enc[i] ? "spot_fwd" : "spot_inv", byte_out, spot_out[i]);
        end

        for (int x = 0; x < 256; x++) begin
            apply(1'b1, 8'(x));
            check("sweep_fwd", byte_out, fwd_tab[x]);
            apply(1'b0, 8'(x));
            check("sweep_inv", byte_out, inv_tab[x]);
        end

        for (int x = 0; x < 256; x++) begin
            apply(1'b1, 8'(x));
            y = byte_out;
            apply(1'b0, y);
            check("round_trip", byte_out, 8'(x));
        end

        apply(1'b1, 8'h53);
        check("toggle_enc1", byte_out, 8'hED);
        apply(1'b0, 8'h53);
        check("toggle_enc0", byte_out, 8'h50);
        apply(1'b1, 8'h53);
        check("toggle_enc1b", byte_out, 8'hED);

        apply(1'b0, 8'hFF);
        check("settle", byte_out, 8'h7D);
        check("q_held_in_reset", byte_out_q, 8'h00);

        @(negedge clk);
        rst_n   = 1'b1;
        encrypt = 1'b1;
        byte_in = 8'h01;
        #1;
        check("q_before_edge", byte_out_q, 8'h00);
        @(posedge clk);
        #1;
        check("q_first_load", byte_out_q, 8'h7C);

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            encrypt = 1'($urandom_range(0, 1));
            byte_in = 8'($urandom_range(0, 255));
            exp_q   = encrypt ? fwd_tab[byte_in] : inv_tab[byte_in];
            #1;
            check("rand_comb", byte_out, exp_q);
            @(posedge clk);
            #1;
            check("rand_q", byte_out_q, exp_q);
        end

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_q", byte_out_q, 8'h00);
        check("comb_in_reset", byte_out, encrypt ? fwd_tab[byte_in] : inv_tab[byte_in]);
        @(posedge clk);
        #1;
        check("q_stays_reset", byte_out_q, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 8'h16);
        check("q_after_release", byte_out_q, 8'h00);
        @(posedge clk);
        #1;
        check("q_reload", byte_out_q, 8'hFF);
        encrypt = 1'b1;
        #1;
        check("dir_switch_comb", byte_out, 8'h47);
        check("dir_switch_q_hold", byte_out_q, 8'hFF);
        @(posedge clk);
        #1;
        check("dir_switch_q", byte_out_q, 8'h47);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
